maxpool_stream: RTL and testbench

Streaming 1-D max-pooling stage placed directly downstream of the convolution block. It consumes the convolution's output vector (LENX signed samples per vector) over a valid/ready handshake and emits the signed maximum of each non-overlapping window of POOL samples. A trailing partial window at the end of each vector is also emitted. Results are buffered in a small output FIFO so that output back-pressure does not stall input acceptance until the FIFO fills.

---
 rtl/maxpool_pkg.sv | 26 ++
 rtl/maxpool_fifo.sv | 61 ++++++
 rtl/maxpool_stream.sv | 101 ++++++++++
 tb/tb_maxpool_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the streaming 1-D max-pool stage.
// Sample type, signed max and the results-per-vector derivation.
package maxpool_pkg;

  localparam int P_WIDTH = 8;
  localparam int P_LENX  = 5;
  localparam int P_POOL  = 2;
  localparam int P_DEPTH = 4;

  typedef logic signed [P_WIDTH-1:0] sample_t;

  function automatic sample_t smax(
    input sample_t a,
    input sample_t b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int ceil_div(
    input int n,
    input int d
  );
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/maxpool_fifo.sv
// Small result FIFO between the pooling window and the consumer.
// Register array with wrapping pointers and an occupancy count.
module maxpool_fifo
  import maxpool_pkg::*;
#(
  parameter int DEPTH = P_DEPTH
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t        r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // a pop at full frees the slot the push lands in
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: signed max over POOL-sample windows,
// trailing partial window flushed at each vector end.
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int LENX  = P_LENX,
  parameter int POOL  = P_POOL,
  parameter int DEPTH = P_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  localparam int LENY = ceil_div(LENX, POOL);
  localparam int IW = (LENX > 1) ? $clog2(LENX) : 1;
  localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int RW = (LENY > 1) ? $clog2(LENY) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LENX - 1);
  localparam logic [CW-1:0] LAST_WIN = CW'(POOL - 1);

  logic [IW-1:0] r_in_idx;
  logic [CW-1:0] r_win_cnt;
  logic [RW-1:0] r_res_idx;
  sample_t       r_acc;

  sample_t w_sample;
  sample_t w_max;
  sample_t w_head;
  logic    w_last;
  logic    w_complete;
  logic    w_in_fire;
  logic    w_out_fire;
  logic    w_full;
  logic    w_empty;

  assign w_sample   = sample_t'(s_data_in_x);
  assign w_last     = (r_in_idx == LAST_IDX);
  assign w_complete = (r_win_cnt == LAST_WIN) || w_last;

  // only registered state here: no path from s_valid_x or m_ready_y
  assign s_ready_x  = reset && !(w_full && w_complete);
  assign w_in_fire  = s_valid_x && s_ready_x;

  assign m_valid_y    = reset && !w_empty;
  assign m_data_out_y = m_valid_y ? w_head : '0;
  assign w_out_fire   = m_valid_y && m_ready_y;

  assign w_max = (r_win_cnt == '0) ? w_sample
                                   : smax(r_acc, w_sample);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_idx  <= '0;
      r_win_cnt <= '0;
      r_res_idx <= '0;
      r_acc     <= '0;
    end else if (w_in_fire) begin
      r_acc <= w_max;
      if (w_complete) begin
        r_win_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end
      if (w_last) begin
        r_in_idx  <= '0;
        r_res_idx <= '0;
      end else begin
        r_in_idx <= r_in_idx + 1'b1;
        if (w_complete) begin
          r_res_idx <= r_res_idx + 1'b1;
        end
      end
    end
  end

  a_res_bound: assert property (
    @(posedge clk) disable iff (!reset)
    int'(r_res_idx) < LENY
  );

  maxpool_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_in_fire && w_complete),
    .i_data  (w_max),
    .i_pop   (w_out_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: vectors, back-pressure,
// random bubbles against a window-max model, mid-vector reset.
module tb_maxpool_stream;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] s_data_in_x;
  logic              s_valid_x;
  logic              s_ready_x;
  logic signed [7:0] m_data_out_y;
  logic              m_valid_y;
  logic              m_ready_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maxpool_stream dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    s_valid_x   = 1'b1;
    s_data_in_x = 8'(x);
    tick();
  endtask

  task automatic idle;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    tick();
  endtask

  int          xs[$];
  int          q[$];
  int          sent;
  int          total;
  int          m;
  logic [7:0]  b;
  logic        stalled;
  logic signed [7:0] held;

  initial begin
    reset       = 1'b0;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    m_ready_y   = 1'b0;
    tick();
    tick();
    chk("rst_ready", s_ready_x, 0);
    chk("rst_valid", m_valid_y, 0);
    chk("rst_data", m_data_out_y, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", s_ready_x, 1);
    chk("post_rst_valid", m_valid_y, 0);

    // basic vector
    m_ready_y = 1'b1;
    send(3);
    chk("b0_valid", m_valid_y, 0);
    send(-7);
    chk("b1_valid", m_valid_y, 1);
    chk("b1_data", m_data_out_y, 3);
    send(12);
    chk("b2_valid", m_valid_y, 0);
    send(5);
    chk("b3_data", m_data_out_y, 12);
    send(-2);
    chk("b4_valid", m_valid_y, 1);
    chk("b4_data", m_data_out_y, -2);
    idle();
    chk("b_drain", m_valid_y, 0);

    // all-negative vector
    send(-1);
    send(-128);
    chk("n0_data", m_data_out_y, -1);
    send(-5);
    send(-3);
    chk("n1_data", m_data_out_y, -3);
    send(-128);
    chk("n2_data", m_data_out_y, -128);
    idle();
    chk("n_drain", m_valid_y, 0);

    // back-pressure: fill FIFO with 20,40,50,20
    m_ready_y = 1'b0;
    for (int v = 0; v < 2; v++) begin
      send(10);
      send(20);
      if (v == 0) begin
        send(30);
        send(40);
        send(50);
      end
    end
    chk("bp_head", m_data_out_y, 20);
    chk("bp_ready_nc", s_ready_x, 1);
    send(30);
    chk("bp_ready_full", s_ready_x, 0);
    s_data_in_x = 8'(40);
    tick();
    chk("bp_hold_ready", s_ready_x, 0);
    chk("bp_hold_data", m_data_out_y, 20);
    m_ready_y = 1'b1;
    #1;
    chk("bp_no_mready_path", s_ready_x, 0);
    tick();
    chk("bp_pop_ready", s_ready_x, 1);
    chk("bp_out1", m_data_out_y, 40);
    send(40);
    chk("bp_out2", m_data_out_y, 50);
    send(50);
    chk("bp_out3", m_data_out_y, 20);
    idle();
    chk("bp_out4", m_data_out_y, 40);
    idle();
    chk("bp_out5", m_data_out_y, 50);
    idle();
    chk("bp_empty", m_valid_y, 0);

    // random bubbles against a window-max model
    total = 250;
    for (int v = 0; v < 50; v++) begin
      for (int i = 0; i < 5; i++) begin
        b = 8'($urandom);
        xs.push_back(int'($signed(b)));
      end
      for (int i = 0; i < 5; i += 2) begin
        m = xs[v*5 + i];
        if (i + 1 < 5 && xs[v*5 + i + 1] > m) begin
          m = xs[v*5 + i + 1];
        end
        q.push_back(m);
      end
    end
    sent    = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0;
         cyc < 5000 && (sent < total || q.size() > 0);
         cyc++) begin
      s_valid_x   = (sent < total) &&
                    ($urandom_range(0, 3) != 0);
      s_data_in_x = (sent < total) ? 8'(xs[sent]) : '0;
      m_ready_y   = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        chk("rand_hold", m_data_out_y, held);
      end
      if (m_valid_y && m_ready_y) begin
        if (q.size() == 0) begin
          chk("rand_spurious", m_valid_y, 0);
        end else begin
          chk("rand_out", m_data_out_y, q.pop_front());
        end
      end
      if (s_valid_x && s_ready_x) begin
        sent++;
      end
      stalled = m_valid_y && !m_ready_y;
      held    = m_data_out_y;
      tick();
    end
    chk("rand_all_sent", sent, total);
    chk("rand_all_out", q.size(), 0);
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    tick();

    // mid-vector reset with two results buffered
    send(1);
    send(2);
    send(3);
    send(4);
    s_valid_x = 1'b0;
    chk("mr_buffered", m_data_out_y, 2);
    reset = 1'b0;
    #1;
    chk("mr_low_valid", m_valid_y, 0);
    chk("mr_low_data", m_data_out_y, 0);
    chk("mr_low_ready", s_ready_x, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_after_valid", m_valid_y, 0);
    chk("mr_after_ready", s_ready_x, 1);
    m_ready_y = 1'b1;
    send(7);
    chk("mr0_valid", m_valid_y, 0);
    send(-9);
    chk("mr0_data", m_data_out_y, 7);
    send(-4);
    send(-2);
    chk("mr1_data", m_data_out_y, -2);
    send(100);
    chk("mr2_data", m_data_out_y, 100);
    idle();
    chk("mr_drain", m_valid_y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
